// File: rtl/usb1_host_port_mux.sv
// usb1_host_port_mux
//   Root-port switch for the USB1.1 host. Several transceiver pad sets share
//   one usb_fs_phy pad interface. Everything runs in the usb_clk_i domain.
//   Each port has a debounced connect detector with a sticky change flag and
//   a host-driven bus reset (SE0). PHY tx/rx traffic goes to one selected
//   port, and the selection only changes while the bus is idle.
//
// Ports
//   usb_clk_i, usb_rstn_i        clock, async active-low reset
//   phy_tx_{dp,dn,oen}_i         PHY transmit pads (oen active low)
//   phy_rx_{rcv,dp,dn}_o         receive pads of the selected port
//   port_in_{dp,dn}_i    [N]     per-port pad inputs
//   port_out_{dp,dn,oen}_o [N]   per-port pad outputs (oen active low)
//   sel_req_i/_valid_i           port switch request (index + strobe)
//   sel_busy_o, sel_cur_o        switch pending / current port
//   port_rst_req_i [N]           strobe that starts a bus reset on a port
//   port_rst_busy_o [N]          port is in bus reset or recovery
//   port_conn_o, port_chg_o [N]  debounced connect status and sticky change
//   port_chg_clr_i [N]           clears the change flag
//   intr_o                       registered OR of port_chg_o
module usb1_host_port_mux #(
    parameter int  NUM_PORTS    = 4,
    parameter int  DEBOUNCE_CYC = 6000000,
    parameter int  RESET_CYC    = 600000,
    parameter int  IDLE_CYC     = 16,
    localparam int PW           = $clog2(NUM_PORTS)
) (
    input  logic                 usb_clk_i,
    input  logic                 usb_rstn_i,
    input  logic                 phy_tx_dp_i,
    input  logic                 phy_tx_dn_i,
    input  logic                 phy_tx_oen_i,
    output logic                 phy_rx_rcv_o,
    output logic                 phy_rx_dp_o,
    output logic                 phy_rx_dn_o,
    input  logic [NUM_PORTS-1:0] port_in_dp_i,
    input  logic [NUM_PORTS-1:0] port_in_dn_i,
    output logic [NUM_PORTS-1:0] port_out_dp_o,
    output logic [NUM_PORTS-1:0] port_out_dn_o,
    output logic [NUM_PORTS-1:0] port_out_oen_o,
    input  logic [PW-1:0]        sel_req_i,
    input  logic                 sel_req_valid_i,
    output logic                 sel_busy_o,
    output logic [PW-1:0]        sel_cur_o,
    input  logic [NUM_PORTS-1:0] port_rst_req_i,
    output logic [NUM_PORTS-1:0] port_rst_busy_o,
    output logic [NUM_PORTS-1:0] port_conn_o,
    output logic [NUM_PORTS-1:0] port_chg_o,
    input  logic [NUM_PORTS-1:0] port_chg_clr_i,
    output logic                 intr_o
);

    localparam int IW   = $clog2(IDLE_CYC + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RMAX = (RESET_CYC > IDLE_CYC) ? RESET_CYC : IDLE_CYC;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_RST   = 2'd1,
        P_RECOV = 2'd2
    } port_state_e;

    logic [PW-1:0]        r_sel_cur, r_pend;
    logic                 r_busy, r_intr;
    logic [IW-1:0]        r_idle_cnt;
    logic [NUM_PORTS-1:0] w_rst_busy, w_chg;
    logic                 w_req_ok, w_idle;

    // Compare in 32 bits so non-power-of-two port counts can reject high indices.
    assign w_req_ok = (32'(sel_req_i) < 32'(NUM_PORTS));
    assign w_idle   = (r_idle_cnt >= IW'(IDLE_CYC));

    always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
        if (!usb_rstn_i) begin
            r_sel_cur  <= '0;
            r_pend     <= '0;
            r_busy     <= 1'b0;
            r_idle_cnt <= '0;
            r_intr     <= 1'b0;
        end else begin
            // The idle counter saturates at IDLE_CYC, so it never wraps back to "busy".
            if (!phy_tx_oen_i)
                r_idle_cnt <= '0;
            else if (!w_idle)
                r_idle_cnt <= r_idle_cnt + IW'(1);
            // A new request takes priority over completing the old one, so the
            // most recent index is always the one that gets selected.
            if (sel_req_valid_i && w_req_ok) begin
                r_pend <= sel_req_i;
                r_busy <= 1'b1;
            end else if (r_busy && w_idle) begin
                r_sel_cur <= r_pend;
                r_busy    <= 1'b0;
            end
            r_intr <= |w_chg;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        port_state_e   r_state, w_state_nxt;
        logic [RW-1:0] r_rcnt, w_rcnt_nxt;
        logic [DW-1:0] r_dcnt;
        logic          r_conn, r_chg, r_dp, r_dn, r_oen;
        logic          w_busy, w_in_rst, w_raw, w_set, w_sel;

        assign w_busy   = (r_state != P_IDLE);
        assign w_in_rst = (r_state == P_RST);
        assign w_raw    = port_in_dp_i[g] | port_in_dn_i[g];
        assign w_sel    = (r_sel_cur == PW'(g));
        // During our own reset/recovery the line shows our SE0, so debounce is held off.
        assign w_set    = !w_busy && (w_raw != r_conn) && (r_dcnt == DW'(DEBOUNCE_CYC - 1));

        always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
            if (!usb_rstn_i) begin
                r_state <= P_IDLE;
                r_rcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            case (r_state)
                P_IDLE: begin
                    if (port_rst_req_i[g]) begin
                        w_state_nxt = P_RST;
                        w_rcnt_nxt  = '0;
                    end
                end
                P_RST: begin
                    if (r_rcnt == RW'(RESET_CYC - 1)) begin
                        w_state_nxt = P_RECOV;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + RW'(1);
                    end
                end
                P_RECOV: begin
                    if (r_rcnt == RW'(IDLE_CYC - 1)) begin
                        w_state_nxt = P_IDLE;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + RW'(1);
                    end
                end
                default: begin
                    w_state_nxt = P_IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
        end

        always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
            if (!usb_rstn_i) begin
                r_dcnt <= '0;
                r_conn <= 1'b0;
                r_chg  <= 1'b0;
            end else begin
                if (w_busy || (w_raw == r_conn)) begin
                    r_dcnt <= '0;
                end else if (w_set) begin
                    r_dcnt <= '0;
                    r_conn <= w_raw;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
                // A new change event beats a simultaneous clear so it is never lost.
                if (w_set)
                    r_chg <= 1'b1;
                else if (port_chg_clr_i[g])
                    r_chg <= 1'b0;
            end
        end

        // Registered pad drive. Bus reset drives SE0, recovery releases the pad,
        // and otherwise only the selected port follows the PHY.
        always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
            if (!usb_rstn_i) begin
                r_oen <= 1'b1;
                r_dp  <= 1'b0;
                r_dn  <= 1'b0;
            end else if (w_in_rst) begin
                r_oen <= 1'b0;
                r_dp  <= 1'b0;
                r_dn  <= 1'b0;
            end else if (w_busy || !w_sel) begin
                r_oen <= 1'b1;
                r_dp  <= 1'b0;
                r_dn  <= 1'b0;
            end else begin
                r_oen <= phy_tx_oen_i;
                r_dp  <= phy_tx_dp_i;
                r_dn  <= phy_tx_dn_i;
            end
        end

        assign port_out_dp_o[g]   = r_dp;
        assign port_out_dn_o[g]   = r_dn;
        assign port_out_oen_o[g]  = r_oen;
        assign port_rst_busy_o[g] = w_busy;
        assign port_conn_o[g]     = r_conn;
        assign port_chg_o[g]      = r_chg;
        assign w_rst_busy[g]      = w_busy;
        assign w_chg[g]           = r_chg;
    end

    // A port in reset/recovery shows SE0 to the PHY rather than our own driven SE0 echo.
    assign phy_rx_dp_o  = port_in_dp_i[r_sel_cur] & ~w_rst_busy[r_sel_cur];
    assign phy_rx_dn_o  = port_in_dn_i[r_sel_cur] & ~w_rst_busy[r_sel_cur];
    assign phy_rx_rcv_o = phy_rx_dp_o;

    assign sel_cur_o  = r_sel_cur;
    assign sel_busy_o = r_busy;
    assign intr_o     = r_intr;

endmodule

// File: tb/tb_usb1_host_port_mux.sv
module tb_usb1_host_port_mux;
    localparam int NP  = 4;
    localparam int DEB = 8;
    localparam int RST = 20;
    localparam int IDL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          tx_dp = 1'b0, tx_dn = 1'b0, tx_oen = 1'b1;
    logic [NP-1:0] in_dp = '0, in_dn = '0, rst_req = '0, chg_clr = '0;
    logic [1:0]    sel_req = '0;
    logic          sel_vld = 1'b0;
    logic          rx_rcv, rx_dp, rx_dn, sel_busy, intr;
    logic [NP-1:0] out_dp, out_dn, out_oen, rst_busy, conn, chg;
    logic [1:0]    sel_cur;

    usb1_host_port_mux #(.NUM_PORTS(NP), .DEBOUNCE_CYC(DEB), .RESET_CYC(RST), .IDLE_CYC(IDL)) dut (
        .usb_clk_i(clk), .usb_rstn_i(rst_n),
        .phy_tx_dp_i(tx_dp), .phy_tx_dn_i(tx_dn), .phy_tx_oen_i(tx_oen),
        .phy_rx_rcv_o(rx_rcv), .phy_rx_dp_o(rx_dp), .phy_rx_dn_o(rx_dn),
        .port_in_dp_i(in_dp), .port_in_dn_i(in_dn),
        .port_out_dp_o(out_dp), .port_out_dn_o(out_dn), .port_out_oen_o(out_oen),
        .sel_req_i(sel_req), .sel_req_valid_i(sel_vld),
        .sel_busy_o(sel_busy), .sel_cur_o(sel_cur),
        .port_rst_req_i(rst_req), .port_rst_busy_o(rst_busy),
        .port_conn_o(conn), .port_chg_o(chg), .port_chg_clr_i(chg_clr),
        .intr_o(intr)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Reference model: per-port "age since reset request" and "run length of a
    // differing line state", plus the cycles the PHY has been idle.
    bit            m_conn[NP], m_chg[NP];
    int            m_run[NP], m_age[NP];
    int            m_cur, m_pend, m_idle;
    bit            m_busy, m_intr;
    bit [NP-1:0]   m_oen, m_dp, m_dn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_conn[p] = 0; m_chg[p] = 0; m_run[p] = 0; m_age[p] = -1;
        end
        m_cur = 0; m_pend = 0; m_idle = 0; m_busy = 0; m_intr = 0;
        m_oen = '1; m_dp = '0; m_dn = '0;
    endtask

    task automatic model_update();
        bit any, busy, inrst, raw, set;
        any = 0;
        for (int p = 0; p < NP; p++) any |= m_chg[p];
        for (int p = 0; p < NP; p++) begin
            busy  = (m_age[p] >= 0);
            inrst = busy && (m_age[p] < RST);
            raw   = in_dp[p] | in_dn[p];
            if (inrst) begin
                m_oen[p] = 0; m_dp[p] = 0; m_dn[p] = 0;
            end else if (busy || m_cur != p) begin
                m_oen[p] = 1; m_dp[p] = 0; m_dn[p] = 0;
            end else begin
                m_oen[p] = tx_oen; m_dp[p] = tx_dp; m_dn[p] = tx_dn;
            end
            set = 0;
            if (busy || raw == m_conn[p]) m_run[p] = 0;
            else begin
                m_run[p]++;
                if (m_run[p] == DEB) begin
                    m_conn[p] = raw; set = 1; m_run[p] = 0;
                end
            end
            if (set) m_chg[p] = 1;
            else if (chg_clr[p]) m_chg[p] = 0;
            if (busy) begin
                m_age[p]++;
                if (m_age[p] == RST + IDL) m_age[p] = -1;
            end else if (rst_req[p]) m_age[p] = 0;
        end
        m_intr = any;
        if (sel_vld && int'(sel_req) < NP) begin
            m_pend = int'(sel_req); m_busy = 1;
        end else if (m_busy && m_idle >= IDL) begin
            m_cur = m_pend; m_busy = 0;
        end
        if (!tx_oen) m_idle = 0;
        else if (m_idle < 1000) m_idle++;
    endtask

    task automatic check_all();
        bit [NP-1:0] e_conn, e_chg, e_rb;
        bit          eb;
        for (int p = 0; p < NP; p++) begin
            e_conn[p] = m_conn[p]; e_chg[p] = m_chg[p]; e_rb[p] = (m_age[p] >= 0);
        end
        eb = (m_age[m_cur] >= 0);
        chk("out_oen", out_oen, m_oen);
        chk("out_dp", out_dp, m_dp);
        chk("out_dn", out_dn, m_dn);
        chk("sel_cur", sel_cur, m_cur);
        chk("sel_busy", sel_busy, m_busy);
        chk("conn", conn, e_conn);
        chk("chg", chg, e_chg);
        chk("rst_busy", rst_busy, e_rb);
        chk("intr", intr, m_intr);
        chk("rx_dp", rx_dp, in_dp[m_cur] & ~eb);
        chk("rx_dn", rx_dn, in_dn[m_cur] & ~eb);
        chk("rx_rcv", rx_rcv, in_dp[m_cur] & ~eb);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_oen"}, out_oen, 4'hF);
        chk({tag, "_dpdn"}, {out_dp, out_dn}, 8'h00);
        chk({tag, "_sel"}, {sel_cur, sel_busy}, 3'b000);
        chk({tag, "_conn_chg"}, {conn, chg}, 8'h00);
        chk({tag, "_rstbusy_intr"}, {rst_busy, intr}, 5'b00000);
        chk({tag, "_rx"}, {rx_rcv, rx_dp, rx_dn}, {in_dp[0], in_dp[0], in_dn[0]});
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    int cnt_oen0, cnt_busy0;

    initial begin
        // power-on reset
        #1 rst_n = 1'b0;
        #2 check_reset("por");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // port 2 connects after DEB cycles, interrupt one cycle later
        in_dp[2] = 1'b1;
        repeat (7) step();
        chk("p2_conn_early", conn[2], 1'b0);
        step();
        chk("p2_conn", conn[2], 1'b1);
        chk("p2_chg", chg[2], 1'b1);
        chk("p2_intr_lag", intr, 1'b0);
        step();
        chk("p2_intr", intr, 1'b1);

        // glitch on port 1 shorter than debounce
        in_dp[1] = 1'b1;
        repeat (5) step();
        in_dp[1] = 1'b0;
        repeat (10) step();
        chk("p1_glitch", {conn[1], chg[1]}, 2'b00);

        // select port 3 while the bus is busy
        tx_oen = 1'b0; sel_req = 2'd3; sel_vld = 1'b1;
        step();
        sel_vld = 1'b0;
        chk("sel_pend", {sel_busy, sel_cur}, {1'b1, 2'd0});
        repeat (5) step();
        tx_oen = 1'b1;
        repeat (4) step();
        chk("sel_wait", {sel_busy, sel_cur}, {1'b1, 2'd0});
        step();
        chk("sel_done", {sel_busy, sel_cur}, {1'b0, 2'd3});
        tx_dp = 1'b1; tx_dn = 1'b0; tx_oen = 1'b0;
        step();
        chk("tx_route", {out_oen, out_dp}, 8'b0111_1000);
        tx_dp = 1'b0; tx_oen = 1'b1;

        // bus reset on port 0; a repeated request while busy is ignored
        in_dp[0] = 1'b1; rst_req[0] = 1'b1;
        step();
        rst_req[0] = 1'b0;
        cnt_oen0 = 0; cnt_busy0 = int'(rst_busy[0]);
        for (int k = 0; k < 30; k++) begin
            rst_req[0] = (k == 10);
            step();
            cnt_oen0  += int'(!out_oen[0]);
            cnt_busy0 += int'(rst_busy[0]);
        end
        rst_req[0] = 1'b0;
        chk("p0_se0_cycles", cnt_oen0, RST);
        chk("p0_busy_cycles", cnt_busy0, RST + IDL);
        chk("p0_conn_frozen", conn[0], 1'b0);

        // change set and clear in the same cycle: set wins
        in_dp[3] = 1'b1;
        repeat (7) step();
        chg_clr[3] = 1'b1;
        step();
        chg_clr[3] = 1'b0;
        chk("p3_set_beats_clr", {conn[3], chg[3]}, 2'b11);
        chg_clr[2] = 1'b1;
        step();
        chg_clr[2] = 1'b0;
        chk("p2_clr", chg[2], 1'b0);

        // later request overwrites the pending one
        tx_oen = 1'b0; sel_req = 2'd1; sel_vld = 1'b1;
        step();
        sel_req = 2'd2;
        step();
        sel_vld = 1'b0; tx_oen = 1'b1;
        repeat (5) step();
        chk("sel_overwrite", {sel_busy, sel_cur}, {1'b0, 2'd2});

        // request for the current port still waits for idle
        tx_oen = 1'b0; sel_req = 2'd2; sel_vld = 1'b1;
        step();
        sel_vld = 1'b0; tx_oen = 1'b1;
        repeat (4) step();
        chk("sel_same_wait", sel_busy, 1'b1);
        step();
        chk("sel_same_done", {sel_busy, sel_cur}, {1'b0, 2'd2});

        // async reset in the middle of a bus reset and a pending switch
        rst_req[1] = 1'b1; tx_oen = 1'b0; sel_req = 2'd0; sel_vld = 1'b1;
        step();
        rst_req[1] = 1'b0; sel_vld = 1'b0;
        repeat (3) step();
        chk("pre_async", {rst_busy[1], sel_busy}, 2'b11);
        #3 rst_n = 1'b0;
        #1 check_reset("async");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 check_reset("async_hold");
        rst_n = 1'b1; tx_oen = 1'b1;
        step();

        // randomized traffic against the model
        for (int it = 0; it < 2000; it++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(15) == 0) {in_dp[p], in_dn[p]} = 2'($urandom_range(3));
                rst_req[p] = ($urandom_range(149) == 0);
                chg_clr[p] = ($urandom_range(9) == 0);
            end
            tx_dp = 1'($urandom_range(1));
            tx_dn = 1'($urandom_range(1));
            if ($urandom_range(5) == 0) tx_oen = ~tx_oen;
            sel_vld = ($urandom_range(19) == 0);
            sel_req = 2'($urandom_range(3));
            step();
        end
        rst_req = '0; chg_clr = '0; sel_vld = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
